kpt_out_serializer: RTL and testbench

Downstream of the keypoint detect/filter stage. Once both keypoint memories are filled, this block reads them back and streams the keypoints on the CORE 16-bit output port (`out_valid`/`out_data`), layer 1 first, then layer 2. It emits one word per cycle with no gaps, and there is no backpressure. It drives the synchronous-read ports of the two keypoint memories directly.

---
 rtl/sift_pkg.sv | 29 ++
 rtl/kpt_out_serializer.sv | 137 +++++++++++++
 tb/tb_kpt_out_serializer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sift_pkg.sv
// Shared constants, keypoint entry layout and serializer states
// for the SIFT keypoint pipeline.
package sift_pkg;

  localparam int KPT_DEPTH = 2000;
  localparam int ROW_W     = 9;
  localparam int COL_W     = 10;
  localparam int ENT_W     = ROW_W + COL_W;
  localparam int IMG_ROWS  = 480;
  localparam int IMG_COLS  = 640;

  localparam logic [3:0] HDR_TAG = 4'hC;

  // Entry layout: row in the upper field, column in the lower.
  localparam int COL_LSB = 0;
  localparam int ROW_LSB = COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_ROW1,
    S_COL1,
    S_HDR2,
    S_ROW2,
    S_COL2,
    S_FIN
  } ser_state_e;

endpackage

// File: rtl/kpt_out_serializer.sv
// Streams both keypoint memories on the 16-bit output port,
// layer 1 then layer 2, one word per cycle.
module kpt_out_serializer
  import sift_pkg::*;
#(
  parameter int KPT_DEPTH = 2000,
  parameter int ADDR_W    = 11,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10,
  parameter int DATA_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      kpt_cnt_1,
  input  logic [ADDR_W-1:0]      kpt_cnt_2,
  output logic                   kpt1_rd_en,
  output logic [ADDR_W-1:0]      kpt1_rd_addr,
  input  logic [ROW_W+COL_W-1:0] kpt1_rd_data,
  output logic                   kpt2_rd_en,
  output logic [ADDR_W-1:0]      kpt2_rd_addr,
  input  logic [ROW_W+COL_W-1:0] kpt2_rd_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(KPT_DEPTH);

  ser_state_e state, state_nxt;

  logic [ADDR_W-1:0]      addr, addr_nxt;
  logic [ADDR_W-1:0]      n1, n2, n_cur;
  logic [ADDR_W-1:0]      addr_inc;
  logic                   more;
  logic                   layer2;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [ROW_W+COL_W-1:0] rd_data;
  logic [ROW_W-1:0]       row_f;
  logic [COL_W-1:0]       col_f;

  function automatic logic [ADDR_W-1:0] clamp(
    input logic [ADDR_W-1:0] c
  );
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  assign layer2 = (state == S_HDR2) ||
                  (state == S_ROW2) ||
                  (state == S_COL2);

  assign n_cur    = layer2 ? n2 : n1;
  assign rd_data  = layer2 ? kpt2_rd_data : kpt1_rd_data;
  assign row_f    = rd_data[COL_W +: ROW_W];
  assign col_f    = rd_data[0 +: COL_W];
  assign addr_inc = addr + 1'b1;
  assign more     = ({1'b0, addr} + 1'b1) < {1'b0, n_cur};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n1 <= '0;
      n2 <= '0;
    end else if (state == S_IDLE && start) begin
      n1 <= clamp(kpt_cnt_1);
      n2 <= clamp(kpt_cnt_2);
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR1;
      end
      S_HDR1, S_HDR2: begin
        out_valid = 1'b1;
        out_data  = {HDR_TAG, layer2, n_cur};
        addr_nxt  = '0;
        if (n_cur != '0) begin
          rd_en     = 1'b1;
          state_nxt = layer2 ? S_ROW2 : S_ROW1;
        end else begin
          state_nxt = layer2 ? S_FIN : S_HDR2;
        end
      end
      S_ROW1, S_ROW2: begin
        out_valid = 1'b1;
        out_data  = {{(DATA_W-ROW_W){1'b0}}, row_f};
        state_nxt = layer2 ? S_COL2 : S_COL1;
      end
      S_COL1, S_COL2: begin
        out_valid = 1'b1;
        out_data  = {{(DATA_W-COL_W){1'b0}}, col_f};
        if (more) begin
          rd_en     = 1'b1;
          rd_addr   = addr_inc;
          addr_nxt  = addr_inc;
          state_nxt = layer2 ? S_ROW2 : S_ROW1;
        end else begin
          state_nxt = layer2 ? S_FIN : S_HDR2;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign kpt1_rd_en   = rd_en & ~layer2;
  assign kpt2_rd_en   = rd_en & layer2;
  assign kpt1_rd_addr = layer2 ? '0 : rd_addr;
  assign kpt2_rd_addr = layer2 ? rd_addr : '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule

// File: tb/tb_kpt_out_serializer.sv
// Directed bench for kpt_out_serializer with synchronous-read
// memory models and an output stream monitor.
module tb_kpt_out_serializer;
  import sift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] kpt_cnt_1 = '0;
  logic [10:0] kpt_cnt_2 = '0;
  logic        kpt1_rd_en, kpt2_rd_en;
  logic [10:0] kpt1_rd_addr, kpt2_rd_addr;
  logic [18:0] kpt1_rd_data = '0;
  logic [18:0] kpt2_rd_data = '0;
  logic        out_valid, busy, done;
  logic [15:0] out_data;

  kpt_out_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .kpt_cnt_1    (kpt_cnt_1),
    .kpt_cnt_2    (kpt_cnt_2),
    .kpt1_rd_en   (kpt1_rd_en),
    .kpt1_rd_addr (kpt1_rd_addr),
    .kpt1_rd_data (kpt1_rd_data),
    .kpt2_rd_en   (kpt2_rd_en),
    .kpt2_rd_addr (kpt2_rd_addr),
    .kpt2_rd_data (kpt2_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [18:0] mem1 [2048];
  logic [18:0] mem2 [2048];

  always @(posedge clk) begin
    if (kpt1_rd_en) kpt1_rd_data <= mem1[kpt1_rd_addr];
    if (kpt2_rd_en) kpt2_rd_data <= mem2[kpt2_rd_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int n_done, done_cyc, n_busy;
  int n_rd1, n_rd2, max1, max2, zero_bad;
  logic [15:0] wq[$];
  int          cq[$];
  logic [15:0] eq[$];

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      wq.push_back(out_data);
      cq.push_back(cyc);
    end
    if (!out_valid && out_data != 16'h0) zero_bad++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
    if (kpt1_rd_en) begin
      n_rd1++;
      if (int'(kpt1_rd_addr) > max1) max1 = int'(kpt1_rd_addr);
    end
    if (kpt2_rd_en) begin
      n_rd2++;
      if (int'(kpt2_rd_addr) > max2) max2 = int'(kpt2_rd_addr);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    cq.delete();
    n_done = 0;
    done_cyc = 0;
    n_busy = 0;
    n_rd1 = 0;
    n_rd2 = 0;
    max1 = -1;
    max2 = -1;
    zero_bad = 0;
  endtask

  task automatic build_exp(input int c1, input int c2);
    int n1, n2;
    n1 = (c1 > 2000) ? 2000 : c1;
    n2 = (c2 > 2000) ? 2000 : c2;
    eq.delete();
    eq.push_back({4'hC, 1'b0, 11'(n1)});
    for (int i = 0; i < n1; i++) begin
      eq.push_back({7'b0, mem1[i][18:10]});
      eq.push_back({6'b0, mem1[i][9:0]});
    end
    eq.push_back({4'hC, 1'b1, 11'(n2)});
    for (int i = 0; i < n2; i++) begin
      eq.push_back({7'b0, mem2[i][18:10]});
      eq.push_back({6'b0, mem2[i][9:0]});
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_timeout", n_done != 0, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int n;
    chk({tag, "_nwords"}, wq.size(), eq.size());
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), wq[i], eq[i]);
    if (wq.size() > 0) begin
      chk({tag, "_contig"}, cq[$] - cq[0], wq.size() - 1);
      chk({tag, "_done_cyc"}, done_cyc, cq[$] + 1);
    end
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_busy_cyc"}, n_busy, eq.size() + 1);
    chk({tag, "_idle_zero"}, zero_bad, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {out_valid, out_data, kpt1_rd_en, kpt1_rd_addr,
              kpt2_rd_en, kpt2_rd_addr, busy, done}, 64'h0);
  endtask

  logic [15:0] t1_words [8] = '{16'hC002, 16'h0005, 16'h0007,
                                16'h01DF, 16'h027F, 16'hC801,
                                16'h0000, 16'h0000};

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end

    // Reset state
    clr();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_busy", busy, 0);

    // n1=2, n2=1 with hand-computed words
    mem1[0] = {9'd5, 10'd7};
    mem1[1] = {9'd479, 10'd639};
    mem2[0] = '0;
    kpt_cnt_1 = 11'd2;
    kpt_cnt_2 = 11'd1;
    clr();
    pulse_start();
    wait_done(100);
    repeat (3) @(posedge clk);
    eq.delete();
    foreach (t1_words[i]) eq.push_back(t1_words[i]);
    check_run("t1");

    // Both layers empty
    kpt_cnt_1 = 11'd0;
    kpt_cnt_2 = 11'd0;
    clr();
    pulse_start();
    wait_done(100);
    repeat (3) @(posedge clk);
    eq.delete();
    eq.push_back(16'hC000);
    eq.push_back(16'hC800);
    check_run("t2");
    chk("t2_no_rd", n_rd1 + n_rd2, 0);

    // Count clamp at depth
    for (int i = 0; i < 2048; i++)
      mem1[i] = {9'($urandom_range(479)), 10'($urandom_range(639))};
    kpt_cnt_1 = 11'd2047;
    kpt_cnt_2 = 11'd0;
    clr();
    pulse_start();
    wait_done(6000);
    repeat (3) @(posedge clk);
    build_exp(2047, 0);
    chk("t3_hdr", (wq.size() > 0) ? wq[0] : 16'h0, 16'hC7D0);
    check_run("t3");
    chk("t3_max_addr", max1, 1999);
    chk("t3_n_rd1", n_rd1, 2000);
    chk("t3_n_rd2", n_rd2, 0);

    // Extra start pulses mid-stream and coincident with FIN
    for (int i = 0; i < 3; i++) begin
      mem1[i] = {9'(10 + i), 10'(100 + i)};
      mem2[i] = {9'(200 + i), 10'(300 + i)};
    end
    kpt_cnt_1 = 11'd3;
    kpt_cnt_2 = 11'd3;
    clr();
    pulse_start();
    repeat (4) @(posedge clk);
    #1 kpt_cnt_1 = 11'd1;
    pulse_start();
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t4_fin_seen", done, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t4_idle_after", busy, 0);
    build_exp(3, 3);
    check_run("t4");

    // Asynchronous reset during ROW2, then a fresh run
    mem1[0] = {9'd1, 10'd2};
    mem1[1] = {9'd3, 10'd4};
    mem2[0] = {9'd5, 10'd6};
    mem2[1] = {9'd7, 10'd8};
    kpt_cnt_1 = 11'd2;
    kpt_cnt_2 = 11'd2;
    clr();
    pulse_start();
    k = 0;
    while (dut.state != S_ROW2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_reach_row2", out_data, 16'h0005);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async_rst");
    @(posedge clk);
    #1 chk_zero("t5_rst_hold");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("t5_no_resume", busy, 0);
    clr();
    pulse_start();
    wait_done(100);
    repeat (3) @(posedge clk);
    build_exp(2, 2);
    check_run("t5");

    // Full depth on both layers with random entries
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = {9'($urandom_range(479)), 10'($urandom_range(639))};
      mem2[i] = {9'($urandom_range(479)), 10'($urandom_range(639))};
    end
    kpt_cnt_1 = 11'd2000;
    kpt_cnt_2 = 11'd2000;
    clr();
    pulse_start();
    wait_done(10000);
    repeat (3) @(posedge clk);
    build_exp(2000, 2000);
    check_run("t6");
    chk("t6_busy", n_busy, 8003);
    chk("t6_max1", max1, 1999);
    chk("t6_max2", max2, 1999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
